// File: rtl/vga_pkg.sv
// vga_pkg: timing constants shared by the VGA timing generator and the
// frame buffer.
//   - 800x480 visible area; horizontal and vertical porch and sync widths
//   - line and frame totals
//   - 11-bit coordinate width
//   - border offsets used by the frame buffer
//   - sync/de bundle type carried through the output delay line
//   - helper that maps "inside the sync window" to a pin level
package vga_pkg;

    // Coordinate width; every counter and compare is done at this width.
    localparam int unsigned COORD_W = 11;

    // Horizontal timing, in pixel clocks.
    localparam int unsigned VGA_H_VISIBLE = 800;
    localparam int unsigned VGA_H_FRONT   = 40;
    localparam int unsigned VGA_H_SYNC    = 128;
    localparam int unsigned VGA_H_BACK    = 88;
    localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT
                                          + VGA_H_SYNC + VGA_H_BACK;   // 1056

    // Vertical timing, in lines.
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 13;
    localparam int unsigned VGA_V_SYNC    = 3;
    localparam int unsigned VGA_V_BACK    = 32;
    localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT
                                          + VGA_V_SYNC + VGA_V_BACK;   // 528

    // Offsets the frame buffer applies when placing its image in the raster.
    localparam int unsigned VGA_H_BORDER  = 144;
    localparam int unsigned VGA_V_BORDER  = 112;

    // Signals that travel together through the pixel-latency delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_bus_t;

    // Pin level for a sync signal: the active level inside the window,
    // the opposite level outside it.
    function automatic logic sync_level(input logic in_window, input logic pol);
        return in_window ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_sync_delay.sv
// sync_delay: DEPTH-stage shift register advanced by an enable.
//   clk    - clock
//   rst_n  - asynchronous active-low reset; every stage loads IDLE
//   en     - shift enable (pixel-clock enable)
//   din    - WIDTH-bit input word
//   dout   - input delayed by DEPTH enabled steps
// With DEPTH=0 the word passes straight through, but is still forced to
// IDLE while reset is held so the outputs match the reset state of the
// staged build.
module sync_delay #(
    parameter int unsigned      DEPTH = 1,
    parameter int unsigned      WIDTH = 1,
    parameter logic [WIDTH-1:0] IDLE  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Clock and enable have no role without stages.
            logic bypass_unused;
            always_comb bypass_unused = clk ^ en;

            always_comb begin
                dout = rst_n ? din : IDLE;
            end
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage[i] <= IDLE;
                    end
                end else if (en) begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            always_comb begin
                dout = stage[DEPTH-1];
            end
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster counter and sync generator for an 800x480 panel.
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   pix_en      - pixel-clock enable; all state advances only when high
//   vga_h       - horizontal pixel count, 0 .. line total - 1
//   vga_v       - vertical line count, 0 .. frame total - 1
//   active      - vga_h/vga_v inside the visible area (same cycle as counters)
//   frame_start - high while the counters sit at the origin and pix_en is high
//   hsync       - horizontal sync, delayed PIPE_DELAY pixel steps
//   vsync       - vertical sync, delayed PIPE_DELAY pixel steps
//   de          - data enable (active), delayed PIPE_DELAY pixel steps
// The delay lets hsync/vsync/de line up with pixel data that downstream
// logic registers PIPE_DELAY stages after reading vga_h/vga_v.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT    = VGA_H_FRONT,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BACK     = VGA_H_BACK,
    parameter int unsigned V_VISIBLE  = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT    = VGA_V_FRONT,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BACK     = VGA_V_BACK,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic [COORD_W-1:0] vga_h,
    output logic [COORD_W-1:0] vga_v,
    output logic               active,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               de
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // All boundaries as 11-bit values so every compare is 11-bit unsigned.
    localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS_END    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_END    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] H_SYNC_START = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] H_SYNC_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_START = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] V_SYNC_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam sync_bus_t IDLE_BUS = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0};

    logic      at_origin;
    logic      h_in_sync;
    logic      v_in_sync;
    sync_bus_t raw_bus;
    sync_bus_t dly_bus;

    // Raster counters. vga_v only moves on the edge where vga_h wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_h <= '0;
            vga_v <= '0;
        end else if (pix_en) begin
            if (vga_h == H_LAST) begin
                vga_h <= '0;
                vga_v <= (vga_v == V_LAST) ? '0 : vga_v + 1'b1;
            end else begin
                vga_h <= vga_h + 1'b1;
            end
        end
    end

    // Everything below is decoded from the registered counters only, so
    // active and the undelayed syncs are consistent with vga_h/vga_v.
    always_comb begin
        at_origin = (vga_h == '0) && (vga_v == '0);
        active    = (vga_h < H_VIS_END) && (vga_v < V_VIS_END);
        h_in_sync = (vga_h >= H_SYNC_START) && (vga_h < H_SYNC_END);
        v_in_sync = (vga_v >= V_SYNC_START) && (vga_v < V_SYNC_END);
    end

    // The counters already sit at the origin while reset is held, so the
    // pulse is also qualified by rst_n to stay low during reset.
    always_comb begin
        frame_start = rst_n && pix_en && at_origin;
    end

    always_comb begin
        raw_bus       = IDLE_BUS;
        raw_bus.hsync = sync_level(h_in_sync, SYNC_POL);
        raw_bus.vsync = sync_level(v_in_sync, SYNC_POL);
        raw_bus.de    = active;
    end

    sync_delay #(
        .DEPTH (PIPE_DELAY),
        .WIDTH ($bits(sync_bus_t)),
        .IDLE  (IDLE_BUS)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .din   (raw_bus),
        .dout  (dly_bus)
    );

    always_comb begin
        hsync = dly_bus.hsync;
        vsync = dly_bus.vsync;
        de    = dly_bus.de;
    end

endmodule
